// File: rtl/dcfifo_pkg.sv
// dcfifo_pkg: shared constants and Gray/binary conversions for both FIFO pointer blocks.
//   PTR_WITH_DEF : default FIFO address width
//   bin2gray     : binary to reflected Gray code (operands zero-extended to 32 bits)
//   gray2bin     : reflected Gray code to binary (operands zero-extended to 32 bits)
package dcfifo_pkg;

    localparam int PTR_WITH_DEF = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter for a PTR_WITH+1 bit pointer.
//   gray_i : Gray-coded pointer in
//   bin_o  : binary pointer out
module gray2bin #(
    parameter int PTR_WITH = dcfifo_pkg::PTR_WITH_DEF
) (
    input  logic [PTR_WITH:0] gray_i,
    output logic [PTR_WITH:0] bin_o
);

    assign bin_o = (PTR_WITH+1)'(dcfifo_pkg::gray2bin(32'(gray_i)));

endmodule

// File: rtl/wptr_full.sv
// wptr_full: write-side pointer, full flag and occupancy level of a dual-clock FIFO.
//   clk_in         : write-domain clock
//   rst_in         : synchronous active-low reset
//   wr_en          : producer write request
//   rd_ptr_sync    : Gray read pointer already synchronized into clk_in
//   wr_ack         : write strobe to RAM (wr_en and not full)
//   wr_addr        : RAM write address
//   wr_ptr_gray    : registered Gray write pointer toward the read domain
//   wr_full        : registered full flag
//   wr_level       : registered occupancy estimate, 0..2**PTR_WITH
//   wr_almost_full : registered level >= AF_THRESH (only with WPTR_AF_EN defined)
// Optional feature macro: WPTR_AF_EN.
module wptr_full
    import dcfifo_pkg::*;
#(
    parameter int PTR_WITH = PTR_WITH_DEF
`ifdef WPTR_AF_EN
    ,
    parameter int AF_THRESH = 2**PTR_WITH - 2
`endif
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                wr_en,
    input  logic [PTR_WITH:0]   rd_ptr_sync,
    output logic                wr_ack,
    output logic [PTR_WITH-1:0] wr_addr,
    output logic [PTR_WITH:0]   wr_ptr_gray,
    output logic                wr_full,
    output logic [PTR_WITH:0]   wr_level
`ifdef WPTR_AF_EN
    ,
    output logic                wr_almost_full
`endif
);

    localparam int PW = PTR_WITH + 1;

    logic [PTR_WITH:0] wbin_q, wbin_d, gray_q, gray_d, level_q, level_d, rbin;
    logic              full_q, full_d;

    gray2bin #(.PTR_WITH(PTR_WITH)) u_rd_g2b (
        .gray_i (rd_ptr_sync),
        .bin_o  (rbin)
    );

    // Reset gates the strobe so the RAM never sees a write during reset.
    assign wr_ack = wr_en && !full_q && rst_in;

    // Full when the next write pointer sits exactly one lap ahead of the read pointer.
    always_comb begin
        wbin_d  = wbin_q + PW'(wr_ack);
        gray_d  = PW'(bin2gray(32'(wbin_d)));
        full_d  = gray_d == {~rd_ptr_sync[PTR_WITH:PTR_WITH-1], rd_ptr_sync[PTR_WITH-2:0]};
        level_d = wbin_d - rbin;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            full_q  <= 1'b0;
            level_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            full_q  <= full_d;
            level_q <= level_d;
        end
    end

`ifdef WPTR_AF_EN
    logic af_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) af_q <= 1'b0;
        else         af_q <= level_d >= PW'(AF_THRESH);
    end

    assign wr_almost_full = af_q;
`endif

    assign wr_addr     = wbin_q[PTR_WITH-1:0];
    assign wr_ptr_gray = gray_q;
    assign wr_full     = full_q;
    assign wr_level    = level_q;

endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: randomized self-checking bench for wptr_full against a write/read count model.
module tb_wptr_full;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] rd_ptr_sync = '0;
    logic       wr_ack;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       wr_full;
    logic [4:0] wr_level;
    logic       wr_almost_full;

    int n_tests = 0;
    int n_fail = 0;

    // Model: writes accepted (mod 32) and registered expectations derived from counts.
    int m_w = 0;
    int m_level = 0;
    bit m_full = 1'b0;
    bit m_af = 1'b0;
    bit ack_seen, ack_exp;

    always #5 clk_in = ~clk_in;

`ifdef WPTR_AF_EN
    wptr_full #(.PTR_WITH(4), .AF_THRESH(14)) dut (
`else
    wptr_full #(.PTR_WITH(4)) dut (
`endif
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .wr_en          (wr_en),
        .rd_ptr_sync    (rd_ptr_sync),
        .wr_ack         (wr_ack),
        .wr_addr        (wr_addr),
        .wr_ptr_gray    (wr_ptr_gray),
        .wr_full        (wr_full),
        .wr_level       (wr_level)
`ifdef WPTR_AF_EN
        ,
        .wr_almost_full (wr_almost_full)
`endif
    );
`ifndef WPTR_AF_EN
    assign wr_almost_full = 1'b0;
`endif

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    // One clock: drive inputs, observe the combinational strobe, advance the model.
    task automatic tick(input bit en, input int rb);
        wr_en = en;
        rd_ptr_sync = to_gray(rb);
        #1;
        ack_seen = wr_ack;
        ack_exp = en && !m_full && rst_in;
        @(posedge clk_in);
        if (!rst_in) begin
            m_w = 0;
            m_level = 0;
            m_full = 0;
            m_af = 0;
        end else begin
            if (ack_exp) m_w = (m_w + 1) % 32;
            m_level = (m_w - rb) & 31;
            m_full = (m_level == 16);
            m_af = (m_level >= 14);
        end
        #1;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        tick(1, 0);
        tick(1, 0);
        n_tests++;
        if (ack_seen !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack_seen); end
        n_tests++;
        if ({wr_ptr_gray, wr_full, wr_level, wr_addr, wr_almost_full} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs gray=%b full=%b level=%0d addr=%0d af=%b want all 0",
                     wr_ptr_gray, wr_full, wr_level, wr_addr, wr_almost_full);
        end
        rst_in = 1'b1;
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            tick(1, 0);
            n_tests++;
            if (ack_seen !== 1'b1 || wr_level !== 5'(i) || wr_ptr_gray !== to_gray(i) || wr_full !== (i == 16)) begin
                n_fail++;
                $display("FAIL fill_%0d ack=%b level=%0d gray=%b full=%b want ack=1 level=%0d gray=%b full=%b",
                         i, ack_seen, wr_level, wr_ptr_gray, wr_full, i, to_gray(i), i == 16);
            end
        end
        n_tests++;
        if (wr_ptr_gray !== 5'b11000) begin n_fail++; $display("FAIL full_gray got %b want 11000", wr_ptr_gray); end
        tick(1, 0);
        n_tests++;
        if (ack_seen !== 1'b0 || wr_ptr_gray !== 5'b11000 || wr_addr !== 4'd0 || wr_full !== 1'b1 || wr_level !== 5'd16) begin
            n_fail++;
            $display("FAIL write_when_full ack=%b gray=%b addr=%0d full=%b level=%0d want 0 11000 0 1 16",
                     ack_seen, wr_ptr_gray, wr_addr, wr_full, wr_level);
        end
    endtask

    task automatic test_drain_one;
        tick(0, 1);
        n_tests++;
        if (wr_full !== 1'b0 || wr_level !== 5'd15) begin
            n_fail++;
            $display("FAIL drain_one full=%b level=%0d want 0 15", wr_full, wr_level);
        end
        tick(1, 1);
        n_tests++;
        if (ack_seen !== 1'b1 || wr_full !== 1'b1 || wr_level !== 5'd16) begin
            n_fail++;
            $display("FAIL refill ack=%b full=%b level=%0d want 1 1 16", ack_seen, wr_full, wr_level);
        end
    endtask

    task automatic test_track;
        int hist[$];
        int accepted = 0;
        int cycles = 0;
        bit wrapped = 0;
        bit ever_full = 0;
        logic [4:0] pg;
        logic [3:0] pa;
        rst_in = 1'b0;
        tick(0, 0);
        rst_in = 1'b1;
        hist = '{0, 0};
        pg = wr_ptr_gray;
        pa = wr_addr;
        while (accepted < 40 && cycles < 400) begin
            tick($urandom_range(0, 3) != 0, hist[0]);
            hist.push_back(m_w);
            void'(hist.pop_front());
            cycles++;
            if (ack_exp) accepted++;
            if (wr_full) ever_full = 1;
            if (pa == 4'd15 && wr_addr == 4'd0) wrapped = 1;
            n_tests++;
            if (wr_ptr_gray != pg && $countones(wr_ptr_gray ^ pg) != 1) begin
                n_fail++;
                $display("FAIL track_hamming from %b to %b want distance 1", pg, wr_ptr_gray);
            end
            n_tests++;
            if (ack_seen !== ack_exp || wr_ptr_gray !== to_gray(m_w) || wr_addr !== 4'(m_w) || wr_level !== 5'(m_level)) begin
                n_fail++;
                $display("FAIL track_state ack=%b gray=%b addr=%0d level=%0d want %b %b %0d %0d",
                         ack_seen, wr_ptr_gray, wr_addr, wr_level, ack_exp, to_gray(m_w), m_w % 16, m_level);
            end
            pg = wr_ptr_gray;
            pa = wr_addr;
        end
        n_tests++;
        if (accepted != 40) begin n_fail++; $display("FAIL track_budget accepted %0d want 40", accepted); end
        n_tests++;
        if (ever_full !== 1'b0 || wrapped !== 1'b1) begin
            n_fail++;
            $display("FAIL track_flags ever_full=%b wrapped=%b want 0 1", ever_full, wrapped);
        end
    endtask

    task automatic test_reset_mid;
        rst_in = 1'b0;
        tick(0, 0);
        rst_in = 1'b1;
        for (int i = 0; i < 7; i++) tick(1, 0);
        n_tests++;
        if (wr_ptr_gray !== to_gray(7) || wr_level !== 5'd7) begin
            n_fail++;
            $display("FAIL pre_reset gray=%b level=%0d want %b 7", wr_ptr_gray, wr_level, to_gray(7));
        end
        rst_in = 1'b0;
        tick(1, 0);
        rst_in = 1'b1;
        n_tests++;
        if (ack_seen !== 1'b0 || wr_ptr_gray !== 5'd0 || wr_level !== 5'd0 || wr_addr !== 4'd0 || wr_full !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset ack=%b gray=%b level=%0d addr=%0d full=%b want all 0",
                     ack_seen, wr_ptr_gray, wr_level, wr_addr, wr_full);
        end
    endtask

    task automatic test_random;
        int rb = 0;
        for (int i = 0; i < 300; i++) begin
            // Read pointer stays legal: never ahead of the writes, never more than a lap behind.
            if ($urandom_range(0, 2) == 0) rb = (m_w - $urandom_range(0, 16)) & 31;
            tick($urandom_range(0, 1), rb);
            n_tests++;
            if (ack_seen !== ack_exp || wr_ptr_gray !== to_gray(m_w) || wr_addr !== 4'(m_w)
                || wr_level !== 5'(m_level) || wr_full !== m_full) begin
                n_fail++;
                $display("FAIL random_%0d ack=%b gray=%b addr=%0d level=%0d full=%b want %b %b %0d %0d %b",
                         i, ack_seen, wr_ptr_gray, wr_addr, wr_level, wr_full,
                         ack_exp, to_gray(m_w), m_w % 16, m_level, m_full);
            end
`ifdef WPTR_AF_EN
            n_tests++;
            if (wr_almost_full !== m_af) begin
                n_fail++;
                $display("FAIL random_af_%0d got %b want %b", i, wr_almost_full, m_af);
            end
`endif
        end
    endtask

`ifdef WPTR_AF_EN
    task automatic test_almost_full;
        rst_in = 1'b0;
        tick(0, 0);
        rst_in = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick(1, 0);
            n_tests++;
            if (wr_almost_full !== (i >= 14) || wr_full !== (i == 16)) begin
                n_fail++;
                $display("FAIL af_%0d af=%b full=%b want %b %b", i, wr_almost_full, wr_full, i >= 14, i == 16);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain_one();
        test_track();
        test_reset_mid();
        test_random();
`ifdef WPTR_AF_EN
        test_almost_full();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 Parameter PTR_WITH, default 4, meaning FIFO address width; pointers are PTR_WITH+1 bits, depth = 2**PTR_WITH.
REQ-002 Parameter AF_THRESH, default 2**PTR_WITH-2, meaning almost-full level threshold (used only when WPTR_AF_EN is defined).
REQ-003 clk_in  input  1  write-domain clock; the only clock; all logic on its rising edge.
REQ-004 rst_in  input  1  synchronous reset, active-low, sampled on the rising edge of clk_in.
REQ-005 wr_en  input  1  write request from the producer.
REQ-006 rd_ptr_sync  input  PTR_WITH+1  Gray read pointer, already synchronized into clk_in by the sync_ptr stage.
REQ-007 wr_ack  output  1  combinational write strobe to the RAM: wr_en AND NOT wr_full.
REQ-008 wr_addr  output  PTR_WITH  RAM write address: low PTR_WITH bits of the binary write pointer.
REQ-009 wr_ptr_gray  output  PTR_WITH+1  registered Gray write pointer, fed to the sync_ptr stage toward the read domain.
REQ-010 wr_full  output  1  registered full flag.
REQ-011 wr_level  output  PTR_WITH+1  registered occupancy estimate, 0..2**PTR_WITH.
REQ-012 wr_almost_full  output  1  registered; present only when WPTR_AF_EN is defined.

Function
REQ-013 Binary write pointer wbin SHALL increment by 1 modulo 2**(PTR_WITH+1) on each edge where wr_ack=1; otherwise it SHALL hold.
REQ-014 wr_ptr_gray SHALL equal bin2gray(wbin_next) registered at the same edge, i.e. it SHALL change in the cycle after the accepted write and SHALL change exactly one bit per increment, wrap included.
REQ-015 wr_full SHALL register (gray_next == {~rd_ptr_sync[PTR_WITH:PTR_WITH-1], rd_ptr_sync[PTR_WITH-2:0]}), where gray_next is the next-state Gray pointer.
REQ-016 wr_full SHALL assert in the cycle after the write that fills the FIFO; a wr_en while wr_full=1 SHALL be dropped (wr_ack=0, no pointer change, no error state).
REQ-017 wr_full SHALL deassert on the first edge after rd_ptr_sync advances; pessimistic (late) deassertion due to synchronizer latency is correct behaviour.
REQ-018 wr_level SHALL register (wbin_next - gray2bin(rd_ptr_sync)) modulo 2**(PTR_WITH+1); it never exceeds 2**PTR_WITH.
REQ-019 Simultaneous wr_en and rd_ptr_sync change: both SHALL be used in the same next-state computation; no priority between them.
REQ-020 wr_addr SHALL wrap from 2**PTR_WITH-1 to 0 while the MSB of wbin toggles.

Reset
REQ-021 With rst_in=0 at an edge: wbin=0, wr_ptr_gray=0, wr_full=0, wr_level=0, wr_almost_full=0, regardless of wr_en.
REQ-022 wr_ack SHALL be 0 during reset cycles; reset mid-operation discards all pointer state; rst_in is asserted by the system simultaneously with the read-side reset.

Configuration
REQ-023 Macro WPTR_AF_EN defined: wr_almost_full port exists and registers (level_next >= AF_THRESH).
REQ-024 WPTR_AF_EN undefined: wr_almost_full port and its logic are absent; all other behaviour identical.

Structure
REQ-025 Package dcfifo_pkg SHALL hold bin2gray/gray2bin functions and the default PTR_WITH constant, shared with the read-side block.
REQ-026 One sub-module gray2bin (combinational, parameter PTR_WITH) SHALL convert rd_ptr_sync for the level computation.

Verification (PTR_WITH=4)
REQ-027 rst_in=0 for 2 cycles with wr_en=1 -> all outputs 0, wr_ack=0.
REQ-028 rd_ptr_sync=0, 16 consecutive writes -> wr_full=1 the cycle after the 16th, wr_ptr_gray=5'b11000, wr_level=16; 17th write gives wr_ack=0, pointers unchanged.
REQ-029 From full, rd_ptr_sync=5'b00001 -> wr_full=0 and wr_level=15 after one edge; next write re-asserts wr_full.
REQ-030 40 writes with rd_ptr_sync tracking wr_ptr_gray two cycles late -> wr_ptr_gray has Hamming distance 1 per change, wr_addr wraps 15->0, wr_full never asserts.
REQ-031 After 7 writes, rst_in=0 for one edge with wr_en=1 -> wbin=0, wr_ptr_gray=0, wr_level=0 next cycle.
REQ-032 WPTR_AF_EN, AF_THRESH=14, rd_ptr_sync=0 -> wr_almost_full=1 the cycle after the 14th write, wr_full=0 until the 16th.
